// File: rtl/arb_mux8way16.sv
// arb_mux8way16: merges eight 16-bit valid/ready producer lanes into one
// registered output stream tagged with the source lane index. Round-robin
// arbitration by default; RR_EN=0 pins the scan start to lane 0, which gives
// fixed priority with lane 0 highest.
module arb_mux8way16 #(
    parameter int WIDTH = 16,
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    input  logic               out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [2:0]       out_sel_q,   out_sel_d;
    logic [2:0]       ptr_q,       ptr_d;

    logic             load;
    logic             found;
    logic             accept;
    logic [2:0]       gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    // Scan lanes ptr, ptr+1, ... (mod 8); the first valid lane wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < 8; k++) begin
            if (!found && in_valid[ptr_q + 3'(k)]) begin
                found   = 1'b1;
                gnt_idx = ptr_q + 3'(k);
            end
        end
    end

    // Grant qualification and handshake back to the producers. rst_n is
    // folded in so no lane sees a ready while the block is held in reset.
    always_comb begin
        load     = !out_valid_q || out_ready;
        accept   = rst_n && load && found;
        gnt_data = in_data[32'(gnt_idx) * WIDTH +: WIDTH];
        in_ready = accept ? (8'b0000_0001 << gnt_idx) : 8'b0000_0000;
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (accept) begin
            // Drain and reload on the same edge simply overwrites the
            // register, so a continuous stream has no bubbles.
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_sel_d   = gnt_idx;
            ptr_d       = gnt_idx + 3'd1;
        end else if (out_ready) begin
            // Plain drain: data/sel keep the last word for visibility.
            out_valid_d = 1'b0;
        end
        if (!RR_EN) begin
            ptr_d = 3'd0;
        end
    end

    // Output register and pointer; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux8way16.sv
// Directed bench for arb_mux8way16 with a reference model and scoreboard.
module tb_arb_mux8way16;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_valid;
    logic [127:0] in_data;
    logic [7:0]   in_ready;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [2:0]   out_sel;
    logic         out_ready;

    logic [7:0]   fp_in_valid;
    logic [127:0] fp_in_data;
    logic [7:0]   fp_in_ready;
    logic         fp_out_valid;
    logic [15:0]  fp_out_data;
    logic [2:0]   fp_out_sel;
    logic         fp_out_ready;

    arb_mux8way16 #(.WIDTH(16), .RR_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    arb_mux8way16 #(.WIDTH(16), .RR_EN(1'b0)) dut_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fp_in_valid),
        .in_data   (fp_in_data),
        .in_ready  (fp_in_ready),
        .out_valid (fp_out_valid),
        .out_data  (fp_out_data),
        .out_sel   (fp_out_sel),
        .out_ready (fp_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } sb_t;

    sb_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    logic        m_ov;
    logic [2:0]  m_ptr;
    logic [15:0] m_last_data;
    logic [2:0]  m_last_sel;
    logic        auto_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ov        = 1'b0;
        m_ptr       = 3'd0;
        m_last_data = 16'h0000;
        m_last_sel  = 3'd0;
    endtask

    task automatic set_lane(input int lane, input logic [15:0] word);
        in_data[lane*16 +: 16] = word;
        in_valid[lane]         = 1'b1;
    endtask

    // One clock: compare against the model just before the edge, advance the
    // model, then return #1 after the edge so stimulus changes stay clear of it.
    task automatic tick();
        logic       m_found;
        logic [2:0] m_g;
        logic [2:0] idx;
        logic [7:0] exp_ready;
        logic       acc;
        sb_t        item;
        @(negedge clk);
        m_found = 1'b0;
        m_g     = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = m_ptr + 3'(k);
            if (!m_found && in_valid[idx]) begin
                m_found = 1'b1;
                m_g     = idx;
            end
        end
        acc       = m_found && (!m_ov || out_ready);
        exp_ready = acc ? (8'b0000_0001 << m_g) : 8'h00;
        check("in_ready", {24'h0, in_ready}, {24'h0, exp_ready});
        check("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
        if (m_ov && sb.size() > 0) begin
            check("out_data", {16'h0, out_data}, {16'h0, sb[0].data});
            check("out_sel", {29'h0, out_sel}, {29'h0, sb[0].sel});
        end else begin
            check("out_data_idle", {16'h0, out_data}, {16'h0, m_last_data});
            check("out_sel_idle", {29'h0, out_sel}, {29'h0, m_last_sel});
        end
        if (m_ov && out_ready && sb.size() > 0) begin
            item        = sb.pop_front();
            m_last_data = item.data;
            m_last_sel  = item.sel;
        end
        if (acc) begin
            item.sel  = m_g;
            item.data = in_data[32'(m_g)*16 +: 16];
            sb.push_back(item);
            m_ov  = 1'b1;
            m_ptr = m_g + 3'd1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc && auto_drop) in_valid[m_g] = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 8'h00;
        in_data      = '0;
        out_ready    = 1'b0;
        fp_in_valid  = 8'h00;
        fp_in_data   = '0;
        fp_out_ready = 1'b1;
        auto_drop    = 1'b1;
        model_reset();

        #2;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", {16'h0, out_data}, 32'h0);
        check("rst_out_sel", {29'h0, out_sel}, 32'h0);
        in_valid = 8'hFF;
        #1;
        check("rst_in_ready", {24'h0, in_ready}, 32'h0);
        in_valid = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All lanes valid from reset: order 0..7,0 with no bubbles.
        out_ready = 1'b1;
        auto_drop = 1'b0;
        for (int i = 0; i < 8; i++) set_lane(i, 16'h1000 + 16'(i));
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rr_valid", {31'h0, out_valid}, 32'h1);
            check("rr_order", {29'h0, out_sel}, k % 8);
            check("rr_data", {16'h0, out_data}, 32'h1000 + (k % 8));
        end
        in_valid  = 8'h00;
        auto_drop = 1'b1;
        tick();
        check("rr_drained", {31'h0, out_valid}, 32'h0);

        // Single word on lane 5, then lane 7 alone (ptr must have moved to 6).
        set_lane(5, 16'hBEEF);
        #1;
        check("single_ready", {24'h0, in_ready}, 32'h20);
        tick();
        check("single_valid", {31'h0, out_valid}, 32'h1);
        check("single_data", {16'h0, out_data}, 32'hBEEF);
        check("single_sel", {29'h0, out_sel}, 32'h5);
        set_lane(4, 16'h4444);
        set_lane(7, 16'h7777);
        #1;
        check("ptr6_ready", {24'h0, in_ready}, 32'h80);
        in_valid[4] = 1'b0;
        tick();
        check("lane7_sel", {29'h0, out_sel}, 32'h7);

        // Wrap: ptr back at 0, lanes 0 and 6 valid -> 0 then 6.
        set_lane(0, 16'h0A0A);
        set_lane(6, 16'h6A6A);
        #1;
        check("wrap_first_ready", {24'h0, in_ready}, 32'h01);
        tick();
        check("wrap_first_sel", {29'h0, out_sel}, 32'h0);
        check("wrap_second_ready", {24'h0, in_ready}, 32'h40);
        tick();
        check("wrap_second_sel", {29'h0, out_sel}, 32'h6);
        tick();

        // Backpressure: stall a lane-1 word, lanes 2 and 3 wait four cycles.
        out_ready = 1'b0;
        set_lane(1, 16'h1111);
        tick();
        set_lane(2, 16'h2222);
        set_lane(3, 16'h3333);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_ready", {24'h0, in_ready}, 32'h0);
            check("bp_data", {16'h0, out_data}, 32'h1111);
            check("bp_sel", {29'h0, out_sel}, 32'h1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_lane2_sel", {29'h0, out_sel}, 32'h2);
        check("bp_lane2_data", {16'h0, out_data}, 32'h2222);
        tick();
        check("bp_lane3_sel", {29'h0, out_sel}, 32'h3);
        tick();
        tick();
        check("bp_once_valid", {31'h0, out_valid}, 32'h0);
        check("bp_once_queue", sb.size(), 32'h0);

        // Async reset mid-stall. Lane 2 leaves ptr at 3, so without the reset
        // lane 3 would win over lane 0 afterwards.
        out_ready = 1'b0;
        set_lane(2, 16'h2B2B);
        tick();
        check("stall_valid", {31'h0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, out_valid}, 32'h0);
        check("arst_data", {16'h0, out_data}, 32'h0);
        check("arst_sel", {29'h0, out_sel}, 32'h0);
        set_lane(3, 16'h3C3C);
        set_lane(0, 16'h0C0C);
        #1;
        check("arst_in_ready", {24'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", {24'h0, in_ready}, 32'h01);
        tick();
        check("post_rst_first", {29'h0, out_sel}, 32'h0);
        tick();
        check("post_rst_second", {29'h0, out_sel}, 32'h3);
        tick();

        // Fixed priority instance: lanes 1 and 4 always valid, only 1 wins.
        fp_in_data[1*16 +: 16] = 16'hF001;
        fp_in_data[4*16 +: 16] = 16'hF004;
        fp_in_valid            = 8'b0001_0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("fp_ready", {24'h0, fp_in_ready}, 32'h02);
            @(posedge clk);
            #1;
            check("fp_sel", {29'h0, fp_out_sel}, 32'h1);
            check("fp_data", {16'h0, fp_out_data}, 32'hF001);
            check("fp_valid", {31'h0, fp_out_valid}, 32'h1);
        end
        fp_in_valid = 8'h00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
